// File: rtl/config_wr_master_if.sv
// Register-map write bus between config_wr_master (master) and the register map (slave).
interface config_wr_master_if;
    logic        wr_cmd;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] wr_keep;
    logic        wr_valid;
    logic        wr_ready;
    logic [1:0]  wr_err;

    modport master (
        output wr_cmd, wr_addr, wr_data, wr_keep,
        input  wr_valid, wr_ready, wr_err
    );

    modport slave (
        input  wr_cmd, wr_addr, wr_data, wr_keep,
        output wr_valid, wr_ready, wr_err
    );
endinterface

// File: rtl/config_wr_master.sv
// Turns 3-beat command frames (addr, data, keep) into one register write and reports one status word
// per frame. Optional macro CFG_WR_RETRY_EN: reissue once on keep-rejected (01/10) responses.
module config_wr_master #(
    parameter int RESP_TIMEOUT = 16,
    parameter int CNT_W        = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [31:0]        s_tdata,
    input  logic               s_tvalid,
    input  logic               s_tlast,
    output logic               s_tready,
    config_wr_master_if.master wr,
    output logic               st_valid,
    output logic [15:0]        st_data,
    input  logic               st_ready,
    output logic [CNT_W-1:0]   ok_count,
    output logic [CNT_W-1:0]   err_count,
    output logic               busy
);

    typedef enum logic [2:0] {
        IDLE, GET_DATA, GET_KEEP, ISSUE, RESP, STATUS, DRAIN
    } state_t;

    localparam int            TW     = $clog2(RESP_TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(RESP_TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic [7:0]        addr_reg, addr_next;
    logic [31:0]       data_reg, data_next;
    logic [31:0]       keep_reg, keep_next;
    logic [TW-1:0]     timer_reg, timer_next;
    logic              retry_reg, retry_next;
    logic [15:0]       st_reg, st_next;
    logic [CNT_W-1:0]  ok_reg, ok_next;
    logic [CNT_W-1:0]  err_reg, err_next;
    logic              ok_inc, err_inc;
    logic              beat;
    logic              retry_allowed;

    function automatic logic [15:0] status_word(input logic [7:0] a, input logic tmo,
                                                input logic ferr, input logic rty,
                                                input logic [1:0] e);
        return {a, 3'b000, tmo, ferr, rty, e};
    endfunction

`ifdef CFG_WR_RETRY_EN
    assign retry_allowed = ~retry_reg;
`else
    assign retry_allowed = 1'b0;
`endif

    // Gated by reset so every output reads 0 while reset is held, even though the FSM sits in IDLE.
    assign s_tready = ~rst_n_i & ((state_reg == IDLE) || (state_reg == GET_DATA) ||
                                  (state_reg == GET_KEEP) || (state_reg == DRAIN));
    assign beat     = s_tvalid & s_tready;

    assign wr.wr_cmd  = (state_reg == ISSUE) & wr.wr_ready;
    assign wr.wr_addr = addr_reg;
    assign wr.wr_data = data_reg;
    assign wr.wr_keep = keep_reg;

    assign st_valid  = (state_reg == STATUS);
    assign st_data   = st_reg;
    assign ok_count  = ok_reg;
    assign err_count = err_reg;
    assign busy      = (state_reg != IDLE);

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        keep_next  = keep_reg;
        timer_next = timer_reg;
        retry_next = retry_reg;
        st_next    = st_reg;
        ok_inc     = 1'b0;
        err_inc    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (beat) begin
                    addr_next  = s_tdata[7:0];
                    retry_next = 1'b0;
                    if (s_tlast) begin
                        err_inc    = 1'b1;
                        st_next    = status_word(s_tdata[7:0], 1'b0, 1'b1, 1'b0, 2'b00);
                        state_next = STATUS;
                    end else begin
                        state_next = GET_DATA;
                    end
                end
            end
            GET_DATA: begin
                if (beat) begin
                    data_next = s_tdata;
                    if (s_tlast) begin
                        err_inc    = 1'b1;
                        st_next    = status_word(addr_reg, 1'b0, 1'b1, 1'b0, 2'b00);
                        state_next = STATUS;
                    end else begin
                        state_next = GET_KEEP;
                    end
                end
            end
            GET_KEEP: begin
                if (beat) begin
                    keep_next = s_tdata;
                    if (s_tlast) begin
                        state_next = ISSUE;
                    end else begin
                        // Overlong frame: report now, then swallow the tail in DRAIN.
                        err_inc    = 1'b1;
                        st_next    = status_word(addr_reg, 1'b0, 1'b1, 1'b0, 2'b00);
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (beat && s_tlast) begin
                    state_next = STATUS;
                end
            end
            ISSUE: begin
                if (wr.wr_ready) begin
                    timer_next = '0;
                    state_next = RESP;
                end
            end
            RESP: begin
                timer_next = timer_reg + 1'b1;
                // An error code wins over a simultaneous wr_valid.
                if (wr.wr_err != 2'b00) begin
                    if (retry_allowed && (wr.wr_err != 2'b11)) begin
                        retry_next = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        err_inc    = 1'b1;
                        st_next    = status_word(addr_reg, 1'b0, 1'b0, retry_reg, wr.wr_err);
                        state_next = STATUS;
                    end
                end else if (wr.wr_valid) begin
                    ok_inc     = 1'b1;
                    st_next    = status_word(addr_reg, 1'b0, 1'b0, retry_reg, 2'b00);
                    state_next = STATUS;
                end else if (timer_reg == T_LAST) begin
                    err_inc    = 1'b1;
                    st_next    = status_word(addr_reg, 1'b1, 1'b0, retry_reg, 2'b00);
                    state_next = STATUS;
                end
            end
            STATUS: begin
                if (st_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ok_next  = (ok_inc  && (ok_reg  != '1)) ? ok_reg  + 1'b1 : ok_reg;
    assign err_next = (err_inc && (err_reg != '1)) ? err_reg + 1'b1 : err_reg;

    always_ff @(posedge clk_i or posedge rst_n_i) begin
        if (rst_n_i) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            data_reg  <= '0;
            keep_reg  <= '0;
            timer_reg <= '0;
            retry_reg <= 1'b0;
            st_reg    <= '0;
            ok_reg    <= '0;
            err_reg   <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            keep_reg  <= keep_next;
            timer_reg <= timer_next;
            retry_reg <= retry_next;
            st_reg    <= st_next;
            ok_reg    <= ok_next;
            err_reg   <= err_next;
        end
    end

endmodule

// File: tb/tb_config_wr_master.sv
// Scoreboard bench for config_wr_master: frames and responder behaviour are chosen up front, the
// expected status words and write commands are queued, and independent monitors pop and compare.
module tb_config_wr_master;
    localparam int T    = 16;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef CFG_WR_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif
    localparam int K_GOOD = 0, K_SHORT0 = 1, K_SHORT1 = 2, K_LONG = 3;

    typedef struct { bit v; bit [1:0] e; int d; } resp_t;
    typedef struct { logic [7:0] a; logic [31:0] d; logic [31:0] k; } cmd_t;
    typedef struct { logic [15:0] st; int ok; int err; } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic [31:0]   s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic          st_valid;
    logic [15:0]   st_data;
    logic          st_ready = 1'b1;
    logic [CW-1:0] ok_count;
    logic [CW-1:0] err_count;
    logic          busy;

    config_wr_master_if wr_if();

    config_wr_master #(.RESP_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .wr(wr_if.master),
        .st_valid(st_valid), .st_data(st_data), .st_ready(st_ready),
        .ok_count(ok_count), .err_count(err_count), .busy(busy)
    );

    always #5 clk_i = ~clk_i;

    resp_t       resp_q[$];
    cmd_t        cmd_q[$];
    exp_t        st_q[$];
    int          checks = 0, errors = 0;
    int          ok_m = 0, err_m = 0;
    int          cyc = 0, cmd_cyc = 0, st_rise_cyc = 0, n_cmd = 0;
    logic [15:0] last_st = '0;
    bit          rand_rdy = 1'b0, wr_rdy_f = 1'b1, st_rdy_f = 1'b1;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    function automatic resp_t rand_resp();
        resp_t r;
        int    k;
        k   = $urandom_range(0, 5);
        r.d = $urandom_range(0, 3);
        case (k)
            0, 1:    begin r.v = 1'b1; r.e = 2'b00; end
            2:       begin r.v = 1'b0; r.e = 2'b11; end
            3:       begin r.v = 1'b0; r.e = 2'($urandom_range(1, 2)); end
            4:       begin r.v = 1'b1; r.e = 2'($urandom_range(1, 3)); end
            default: begin r.v = 1'b0; r.e = 2'b00; end
        endcase
        return r;
    endfunction

    // Ready drivers: random in the soak phase, forced by the directed tests otherwise.
    initial begin
        wr_if.wr_ready = 1'b1;
        forever begin
            @(posedge clk_i); #1;
            if (rand_rdy) begin
                wr_if.wr_ready = ($urandom_range(0, 3) != 0);
                st_ready       = ($urandom_range(0, 2) != 0);
            end else begin
                wr_if.wr_ready = wr_rdy_f;
                st_ready       = st_rdy_f;
            end
        end
    end

    // Responder model: checks each write strobe and replays the planned response.
    initial begin
        cmd_t  c;
        resp_t r;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_err   = 2'b00;
        forever begin
            @(negedge clk_i);
            if (!rst_n_i && wr_if.wr_cmd) begin
                cmd_cyc = cyc;
                n_cmd++;
                if (cmd_q.size() == 0 || resp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_wr_cmd got addr=%0h want none", wr_if.wr_addr);
                end else begin
                    c = cmd_q.pop_front();
                    r = resp_q.pop_front();
                    check("wr_cmd_bus", {wr_if.wr_addr, wr_if.wr_data, wr_if.wr_keep}, {c.a, c.d, c.k});
                    if (r.v || r.e != 2'b00) begin
                        @(posedge clk_i);
                        repeat (r.d) @(posedge clk_i);
                        #1;
                        wr_if.wr_valid = r.v;
                        wr_if.wr_err   = r.e;
                        @(posedge clk_i); #1;
                        wr_if.wr_valid = 1'b0;
                        wr_if.wr_err   = 2'b00;
                    end
                end
            end
        end
    end

    // Status monitor.
    initial begin
        bit          prev_v, prev_hs;
        logic [15:0] hold;
        exp_t        x;
        prev_v = 1'b0; prev_hs = 1'b0; hold = '0;
        forever begin
            @(negedge clk_i);
            if (rst_n_i) begin
                prev_v = 1'b0;
            end else if (st_valid) begin
                if (!prev_v || prev_hs) st_rise_cyc = cyc;
                else check("st_data_hold", st_data, hold);
                check("status_blocks_input", {s_tready, busy}, 2'b01);
                hold    = st_data;
                prev_hs = st_ready;
                if (st_ready) begin
                    if (st_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_status got=%04h want none", st_data);
                    end else begin
                        x = st_q.pop_front();
                        check("st_data", st_data, x.st);
                        check("ok_count", ok_count, x.ok);
                        check("err_count", err_count, x.err);
                        last_st = st_data;
                        $display("status %04h ok=%0d err=%0d", st_data, ok_count, err_count);
                    end
                end
                prev_v = 1'b1;
            end else begin
                prev_v = 1'b0;
            end
        end
    end

    task automatic drive_beat(input logic [31:0] d, input bit last);
        int n;
        n = 0;
        s_tdata = d; s_tlast = last; s_tvalid = 1'b1;
        do begin @(negedge clk_i); n++; end while (!s_tready && n < 400);
        if (!s_tready) begin
            checks++; errors++;
            $display("FAIL beat_accept_timeout got s_tready=0 want 1");
        end
        @(posedge clk_i); #1;
        s_tvalid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
    endtask

    task automatic send_frame(input int kind, input logic [7:0] a, input logic [31:0] d,
                              input logic [31:0] k, input int extra,
                              input resp_t r1, input resp_t r2);
        exp_t        x;
        cmd_t        c;
        resp_t       fin;
        bit          rty;
        logic [31:0] b0;
        b0 = ($urandom() & 32'hFFFF_FF00) | {24'h0, a};
        if (kind != K_GOOD) begin
            err_m = sat(err_m);
            x.st  = {a, 8'h08};
        end else begin
            c = '{a, d, k};
            cmd_q.push_back(c);
            resp_q.push_back(r1);
            rty = RETRY_EN && (r1.e == 2'b01 || r1.e == 2'b10);
            fin = rty ? r2 : r1;
            if (rty) begin
                cmd_q.push_back(c);
                resp_q.push_back(r2);
            end
            if (fin.e != 2'b00) begin
                err_m = sat(err_m);
                x.st  = {a, 3'b000, 1'b0, 1'b0, rty, fin.e};
            end else if (fin.v) begin
                ok_m = sat(ok_m);
                x.st = {a, 3'b000, 1'b0, 1'b0, rty, 2'b00};
            end else begin
                err_m = sat(err_m);
                x.st  = {a, 3'b000, 1'b1, 1'b0, rty, 2'b00};
            end
        end
        x.ok = ok_m; x.err = err_m;
        st_q.push_back(x);
        case (kind)
            K_SHORT0: drive_beat(b0, 1'b1);
            K_SHORT1: begin drive_beat(b0, 1'b0); drive_beat(d, 1'b1); end
            K_GOOD:   begin drive_beat(b0, 1'b0); drive_beat(d, 1'b0); drive_beat(k, 1'b1); end
            default: begin
                drive_beat(b0, 1'b0); drive_beat(d, 1'b0); drive_beat(k, 1'b0);
                for (int i = 0; i < extra; i++) drive_beat($urandom(), (i == extra - 1));
            end
        endcase
    endtask

    task automatic wait_status(input int bound);
        int n;
        n = 0;
        while (st_q.size() != 0 && n < bound) begin @(negedge clk_i); n++; end
        if (st_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL status_timeout got pending=%0d want 0", st_q.size());
            st_q.delete();
        end
    endtask

    initial begin
        resp_t r_ok, r_e11, r_e01, r_tmo, r1, r2;
        int    c0, n;
        r_ok = '{1'b1, 2'b00, 0}; r_e11 = '{1'b0, 2'b11, 0};
        r_e01 = '{1'b0, 2'b01, 0}; r_tmo = '{1'b0, 2'b00, 0};

        #2 rst_n_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("rst_outputs", {s_tready, st_valid, st_data, busy, wr_if.wr_cmd, wr_if.wr_addr},
              '0);
        check("rst_bus", {wr_if.wr_data, wr_if.wr_keep}, '0);
        check("rst_counters", {ok_count, err_count}, '0);
        @(posedge clk_i); #1 rst_n_i = 1'b0;
        repeat (2) begin @(posedge clk_i); #1; end

        // Nominal write, 1-cycle responder.
        c0 = n_cmd;
        send_frame(K_GOOD, 8'h05, 32'h14, 32'hFFFF_FFF0, 0, r_ok, r_ok);
        wait_status(200);
        check("tp1_status", last_st, 16'h0500);
        check("tp1_ok_count", ok_count, 1);
        check("tp1_latency", st_rise_cyc - cmd_cyc, 2);
        check("tp1_cmds", n_cmd - c0, 1);

        // Bad address.
        c0 = n_cmd;
        send_frame(K_GOOD, 8'h05, 32'h14, 32'hFFFF_FFF0, 0, r_e11, r_ok);
        wait_status(200);
        check("tp2_status", last_st, 16'h0503);
        check("tp2_err_count", err_count, 1);
        check("tp2_cmds", n_cmd - c0, 1);

        // Keep reject followed by success on the reissue, when reissue is enabled.
        c0 = n_cmd;
        send_frame(K_GOOD, 8'h05, 32'h14, 32'hFFFF_FFF0, 0, r_e01, r_ok);
        wait_status(200);
        check("tp3_status", last_st, RETRY_EN ? 16'h0504 : 16'h0501);
        check("tp3_cmds", n_cmd - c0, RETRY_EN ? 2 : 1);

        // Short and long frames.
        c0 = n_cmd;
        send_frame(K_SHORT1, 8'h3C, 32'h1234_5678, 32'h0, 0, r_ok, r_ok);
        wait_status(200);
        check("tp4_status", last_st, 16'h3C08);
        send_frame(K_LONG, 8'h7E, 32'h0BAD_F00D, 32'hFFFF_FFFF, 1, r_ok, r_ok);
        wait_status(200);
        check("tp5_status", last_st, 16'h7E08);
        check("tp45_no_cmd", n_cmd - c0, 0);

        // Stalled wr_ready, silent responder, slow status consumer.
        wr_rdy_f = 1'b0; st_rdy_f = 1'b0;
        repeat (2) begin @(posedge clk_i); #1; end
        send_frame(K_GOOD, 8'hA5, 32'hCAFE_0001, 32'h0000_00FF, 0, r_tmo, r_tmo);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            check("stall_busy_no_cmd", {busy, wr_if.wr_cmd}, 2'b10);
        end
        @(posedge clk_i); #1 wr_rdy_f = 1'b1;
        n = 0;
        while (!st_valid && n < T + 20) begin @(negedge clk_i); n++; end
        check("tmo_status_seen", st_valid, 1'b1);
        check("tmo_latency", st_rise_cyc - cmd_cyc, T + 1);
        s_tdata = 32'h0000_0011; s_tlast = 1'b0; s_tvalid = 1'b1;
        repeat (10) @(negedge clk_i);
        check("tmo_held_status", {st_valid, st_data}, {1'b1, 16'hA510});
        @(posedge clk_i); #1 s_tvalid = 1'b0; st_rdy_f = 1'b1;
        wait_status(50);
        check("tmo_status", last_st, 16'hA510);

        // Reset in the middle of a frame: abandoned, counters cleared, nothing reported.
        drive_beat(32'h0000_0042, 1'b0);
        drive_beat(32'h0000_0099, 1'b0);
        @(negedge clk_i);
        check("mid_busy", busy, 1'b1);
        @(posedge clk_i); #1 rst_n_i = 1'b1;
        @(negedge clk_i);
        check("mid_reset_outputs", {busy, st_valid, ok_count, err_count}, '0);
        @(posedge clk_i); #1 rst_n_i = 1'b0;
        ok_m = 0; err_m = 0;
        repeat (3) @(negedge clk_i);
        check("mid_reset_quiet", {st_valid, busy, wr_if.wr_cmd}, '0);

        // Randomized soak; small counters saturate along the way.
        rand_rdy = 1'b1;
        for (int f = 0; f < 60; f++) begin
            int kr, kind;
            kr   = $urandom_range(0, 9);
            kind = (kr < 6) ? K_GOOD : (kr == 6) ? K_SHORT0 : (kr == 7) ? K_SHORT1 : K_LONG;
            r1 = rand_resp();
            r2 = rand_resp();
            send_frame(kind, 8'($urandom()), $urandom(), $urandom(), $urandom_range(1, 3), r1, r2);
        end
        wait_status(2000);
        rand_rdy = 1'b0;
        repeat (4) @(negedge clk_i);
        check("final_counters", {ok_count, err_count}, {4'(ok_m), 4'(err_m)});
        check("queues_empty", cmd_q.size() + resp_q.size() + st_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "global timeout");
    end
endmodule
